// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared types and widths for the CPU's external SRAM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int SRAM_ADDR_W = 18;
   localparam int WORD_W      = 16;
   localparam int STROBE_CNT_W = 4;

   typedef enum logic [1:0] {
      SRAM_IDLE   = 2'd0,
      SRAM_SETUP  = 2'd1,
      SRAM_STROBE = 2'd2,
      SRAM_FINISH = 2'd3
   } sram_state_t;

   typedef enum logic {
      OWNER_IF  = 1'b0,
      OWNER_MEM = 1'b1
   } sram_owner_t;

   // Everything captured from a port at the moment it wins arbitration.
   typedef struct packed {
      sram_owner_t         owner;
      logic                we;
      logic [WORD_W-1:0]   addr;
      logic [WORD_W-1:0]   wdata;
   } sram_grant_t;

   function automatic logic [SRAM_ADDR_W-1:0] to_ram_addr(input logic [WORD_W-1:0] word_addr);
      return {{(SRAM_ADDR_W-WORD_W){1'b0}}, word_addr};
   endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter
//  Purpose  : Shares one 16-bit async SRAM between the fetch and data ports,
//             running each access as setup / strobe / hold (finish) phases.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter
   import cpu_pkg::*;
#(
   parameter int STROBE_CYCLES = 1
)
(
   input  logic                   clk,
   input  logic                   rst,

   input  logic                   ifReq,
   input  logic [WORD_W-1:0]      ifAddr,
   output logic [WORD_W-1:0]      ifData,
   output logic                   ifAck,

   input  logic                   memReq,
   input  logic                   memWe,
   input  logic [WORD_W-1:0]      memAddr,
   input  logic [WORD_W-1:0]      memWData,
   output logic [WORD_W-1:0]      memRData,
   output logic                   memAck,

   output logic                   busy,

   output logic [SRAM_ADDR_W-1:0] ramAddr,
   output logic [WORD_W-1:0]      ramInputData,
   input  logic [WORD_W-1:0]      ramOutputData,
   output logic                   ramEN,
   output logic                   ramOE,
   output logic                   ramWE
);

   localparam logic [STROBE_CNT_W-1:0] C_STROBE_LOAD = STROBE_CNT_W'(STROBE_CYCLES - 1);

   sram_state_t             state_q, state_d;
   sram_owner_t             owner_q;
   logic                    we_q;
   logic [WORD_W-1:0]       addr_q;
   logic [WORD_W-1:0]       wdata_q;
   logic [STROBE_CNT_W-1:0] cnt_q;
   logic [WORD_W-1:0]       ifData_q;
   logic [WORD_W-1:0]       memRData_q;

   logic                    grant_valid;
   logic                    grant_take;
   logic                    mem_eligible;
   logic                    if_eligible;
   logic                    strobe_last;
   sram_grant_t             grant_d;

   // Arbitration: in FINISH the current owner's request is masked so a req
   // still held during its own ack cycle cannot be granted a second time.
   always_comb begin
      mem_eligible = memReq && !(state_q == SRAM_FINISH && owner_q == OWNER_MEM);
      if_eligible  = ifReq  && !(state_q == SRAM_FINISH && owner_q == OWNER_IF);
      grant_valid  = mem_eligible || if_eligible;

      grant_d.owner = OWNER_IF;
      grant_d.we    = 1'b0;
      grant_d.addr  = ifAddr;
      grant_d.wdata = '0;
      if (mem_eligible) begin
         grant_d.owner = OWNER_MEM;
         grant_d.we    = memWe;
         grant_d.addr  = memAddr;
         grant_d.wdata = memWe ? memWData : '0;
      end
   end

   assign grant_take  = grant_valid && (state_q == SRAM_IDLE || state_q == SRAM_FINISH);
   assign strobe_last = (state_q == SRAM_STROBE) && (cnt_q == '0);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SRAM_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SRAM_IDLE:   if (grant_valid) state_d = SRAM_SETUP;
         SRAM_SETUP:  state_d = SRAM_STROBE;
         SRAM_STROBE: if (cnt_q == '0) state_d = SRAM_FINISH;
         SRAM_FINISH: state_d = grant_valid ? SRAM_SETUP : SRAM_IDLE;
         default:     state_d = SRAM_IDLE;
      endcase
   end

   always_comb begin
      ramEN  = 1'b1;
      ramOE  = 1'b1;
      ramWE  = 1'b1;
      ifAck  = 1'b0;
      memAck = 1'b0;
      busy   = 1'b1;
      case (state_q)
         SRAM_IDLE: begin
            busy = 1'b0;
         end
         SRAM_SETUP: begin
            ramEN = 1'b0;
         end
         SRAM_STROBE: begin
            ramEN = 1'b0;
            ramOE = we_q;
            ramWE = !we_q;
         end
         SRAM_FINISH: begin
            ramEN  = 1'b0;
            ifAck  = (owner_q == OWNER_IF);
            memAck = (owner_q == OWNER_MEM);
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWNER_IF;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (grant_take) begin
         owner_q <= grant_d.owner;
         we_q    <= grant_d.we;
         addr_q  <= grant_d.addr;
         wdata_q <= grant_d.wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (state_q == SRAM_SETUP) begin
         cnt_q <= C_STROBE_LOAD;
      end else if (state_q == SRAM_STROBE && cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // Read data is captured on the closing edge of the strobe, while OE is
   // still asserted, and lands in the owner's result register only.
   always_ff @(posedge clk) begin
      if (rst) begin
         ifData_q   <= '0;
         memRData_q <= '0;
      end else if (strobe_last && !we_q) begin
         if (owner_q == OWNER_IF) begin
            ifData_q <= ramOutputData;
         end else begin
            memRData_q <= ramOutputData;
         end
      end
   end

   assign ifData       = ifData_q;
   assign memRData     = memRData_q;
   assign ramAddr      = to_ram_addr(addr_q);
   assign ramInputData = (state_q != SRAM_IDLE) ? wdata_q : '0;

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_arbiter
//  Purpose  : Directed, table-driven bench for sram_arbiter with an SRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;
   import cpu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        ifReq, memReq, memWe;
   logic [15:0] ifAddr, memAddr, memWData;
   logic [15:0] ifData, memRData;
   logic        ifAck, memAck, busy;
   logic [17:0] ramAddr;
   logic [15:0] ramInputData, ramOutputData;
   logic        ramEN, ramOE, ramWE;

   logic        ifReq2, memReq2, memWe2;
   logic [15:0] ifAddr2, memAddr2, memWData2;
   logic [15:0] ifData2, memRData2;
   logic        ifAck2, memAck2, busy2;
   logic [17:0] ramAddr2;
   logic [15:0] ramInputData2, ramOutputData2;
   logic        ramEN2, ramOE2, ramWE2;

   int checks   = 0;
   int failures = 0;

   sram_arbiter #(.STROBE_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifAck(ifAck),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
      .memRData(memRData), .memAck(memAck), .busy(busy),
      .ramAddr(ramAddr), .ramInputData(ramInputData), .ramOutputData(ramOutputData),
      .ramEN(ramEN), .ramOE(ramOE), .ramWE(ramWE)
   );

   sram_arbiter #(.STROBE_CYCLES(4)) dut_ws (
      .clk(clk), .rst(rst),
      .ifReq(ifReq2), .ifAddr(ifAddr2), .ifData(ifData2), .ifAck(ifAck2),
      .memReq(memReq2), .memWe(memWe2), .memAddr(memAddr2), .memWData(memWData2),
      .memRData(memRData2), .memAck(memAck2), .busy(busy2),
      .ramAddr(ramAddr2), .ramInputData(ramInputData2), .ramOutputData(ramOutputData2),
      .ramEN(ramEN2), .ramOE(ramOE2), .ramWE(ramWE2)
   );

   // Behavioural async SRAMs; preload happens while reset is held.
   logic [15:0] mem1 [0:65535];
   logic [15:0] mem2 [0:65535];

   always @(posedge clk) begin
      if (rst) begin
         mem1[16'h0010] <= 16'hBEEF;
         mem1[16'h0020] <= 16'h5A5A;
      end else if (!ramEN && !ramWE) begin
         mem1[ramAddr[15:0]] <= ramInputData;
      end
   end
   assign ramOutputData = (!ramEN && !ramOE) ? mem1[ramAddr[15:0]] : 16'h0000;

   always @(posedge clk) begin
      if (rst) begin
         mem2[16'h0033] <= 16'hC0DE;
      end else if (!ramEN2 && !ramWE2) begin
         mem2[ramAddr2[15:0]] <= ramInputData2;
      end
   end
   assign ramOutputData2 = (!ramEN2 && !ramOE2) ? mem2[ramAddr2[15:0]] : 16'h0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Per-cycle pin monitor; strobe totals only ever grow here.
   int oe_total = 0, we_total = 0;
   int oe2_total = 0, oe2_run = 0, oe2_max = 0;
   always @(negedge clk) begin
      if (!rst) begin
         check("oe_we_exclusive", {31'd0, (!ramOE && !ramWE)}, 32'd0);
         check("en_iff_busy", {31'd0, ramEN}, {31'd0, !busy});
         check("ws_en_iff_busy", {31'd0, ramEN2}, {31'd0, !busy2});
         if (!ramOE) oe_total++;
         if (!ramWE) we_total++;
         if (!ramOE2) begin
            oe2_total++;
            oe2_run++;
            if (oe2_run > oe2_max) oe2_max = oe2_run;
         end else begin
            oe2_run = 0;
         end
      end
   end

   // Issues one request on the default-timing DUT and returns in the ack
   // cycle (1 ns after its edge). Port inputs are scrambled after the ack
   // so the held pins prove the values were latched at grant.
   task automatic do_txn(input logic is_mem, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input bit hold, output int lat);
      @(negedge clk);
      if (is_mem) begin
         memReq = 1'b1; memWe = we; memAddr = addr; memWData = wdata;
      end else begin
         ifReq = 1'b1; ifAddr = addr;
      end
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if ((is_mem && memAck) || (!is_mem && ifAck)) begin
            lat = k;
            break;
         end
      end
      if (!hold || lat < 0) begin
         memReq = 1'b0;
         ifReq  = 1'b0;
      end
      memAddr = 16'hFFFF; memWData = 16'h0000; memWe = ~memWe; ifAddr = 16'hFFFF;
   endtask

   typedef struct {
      logic        is_mem;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int lat, mem_lat, if_lat, idle_gap, oe0, we0, acks;
      logic [15:0] exp_if, exp_mem;

      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, mem_lat, if_lat, idle_gap, oe0, we0, acks;
      logic [15:0] exp_if, exp_mem;

      vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
      vecs[1] = '{1'b1, 1'b1, 16'h1234, 16'hA5A5, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'hA5A5};
      vecs[3] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hA5A5};
      vecs[4] = '{1'b1, 1'b1, 16'h0010, 16'h1111, 16'h0000};
      vecs[5] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1111};
      vecs[6] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h5A5A};

      rst = 1'b1;
      ifReq = 0; memReq = 0; memWe = 0; ifAddr = 0; memAddr = 0; memWData = 0;
      ifReq2 = 0; memReq2 = 0; memWe2 = 0; ifAddr2 = 0; memAddr2 = 0; memWData2 = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pins", {29'd0, ramEN, ramOE, ramWE}, 32'h7);
      check("rst_addr", {14'd0, ramAddr}, 32'd0);
      check("rst_wdata", {16'd0, ramInputData}, 32'd0);
      check("rst_data", {ifData, memRData}, 32'd0);
      check("rst_ack_busy", {29'd0, ifAck, memAck, busy}, 32'd0);
      rst = 1'b0;
      exp_if = 16'h0000;
      exp_mem = 16'h0000;

      for (int i = 0; i < 7; i++) begin
         oe0 = oe_total;
         we0 = we_total;
         do_txn(vecs[i].is_mem, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, lat);
         check($sformatf("v%0d_latency", i), lat, 32'd3);
         check($sformatf("v%0d_hold_addr", i), {14'd0, ramAddr}, {16'd0, vecs[i].addr});
         check($sformatf("v%0d_hold_wdata", i), {16'd0, ramInputData},
               {16'd0, (vecs[i].we ? vecs[i].wdata : 16'h0000)});
         check($sformatf("v%0d_hold_en", i), {31'd0, ramEN}, 32'd0);
         if (!vecs[i].we) begin
            if (vecs[i].is_mem) exp_mem = vecs[i].exp_rd;
            else                exp_if  = vecs[i].exp_rd;
         end
         check($sformatf("v%0d_ifData", i), {16'd0, ifData}, {16'd0, exp_if});
         check($sformatf("v%0d_memRData", i), {16'd0, memRData}, {16'd0, exp_mem});
         @(posedge clk); #1;
         check($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
         check($sformatf("v%0d_oe_cycles", i), oe_total - oe0, vecs[i].we ? 32'd0 : 32'd1);
         check($sformatf("v%0d_we_cycles", i), we_total - we0, vecs[i].we ? 32'd1 : 32'd0);
      end

      // Contention: data read of 0x0010 beats fetch of 0x1234, no idle gap.
      @(negedge clk);
      memReq = 1'b1; memWe = 1'b0; memAddr = 16'h0010;
      ifReq = 1'b1; ifAddr = 16'h1234;
      mem_lat = -1; if_lat = -1; idle_gap = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (memAck && mem_lat < 0) begin
            mem_lat = k; memReq = 1'b0;
            check("cont_memRData", {16'd0, memRData}, 32'h1111);
         end
         if (ifAck && if_lat < 0) begin
            if_lat = k; ifReq = 1'b0;
            check("cont_ifData", {16'd0, ifData}, 32'hA5A5);
         end
         if (!busy && mem_lat > 0 && if_lat < 0) idle_gap++;
         if (mem_lat > 0 && if_lat > 0) break;
      end
      memReq = 1'b0; ifReq = 1'b0;
      check("cont_mem_latency", mem_lat, 32'd3);
      check("cont_if_latency", if_lat, 32'd6);
      check("cont_idle_gap", idle_gap, 32'd0);
      @(posedge clk); #1;

      // Wait states on the STROBE_CYCLES=4 instance.
      @(negedge clk);
      ifReq2 = 1'b1; ifAddr2 = 16'h0033;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (ifAck2) begin lat = k; break; end
      end
      ifReq2 = 1'b0;
      check("ws_latency", lat, 32'd6);
      check("ws_ifData", {16'd0, ifData2}, 32'hC0DE);
      check("ws_oe_total", oe2_total, 32'd4);
      check("ws_oe_run", oe2_max, 32'd4);

      // Request held high through its own ack cycle: one grant only.
      do_txn(1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, lat);
      check("hold_latency", lat, 32'd3);
      check("hold_memRData", {16'd0, memRData}, 32'hA5A5);
      @(posedge clk); #1;
      memReq = 1'b0;
      check("hold_idle", {31'd0, busy}, 32'd0);
      acks = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (memAck) acks++;
      end
      check("hold_extra_acks", acks, 32'd0);

      // Reset in the strobe cycle of a write.
      @(negedge clk);
      memReq = 1'b1; memWe = 1'b1; memAddr = 16'h0040; memWData = 16'h7777;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rstmid_strobe_we", {31'd0, ramWE}, 32'd0);
      rst = 1'b1; memReq = 1'b0;
      @(posedge clk); #1;
      check("rstmid_pins", {29'd0, ramEN, ramOE, ramWE}, 32'h7);
      check("rstmid_ack_busy", {29'd0, ifAck, memAck, busy}, 32'd0);
      check("rstmid_data", {ifData, memRData}, 32'd0);
      rst = 1'b0;
      acks = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (memAck || ifAck || busy) acks++;
      end
      check("rstmid_quiet", acks, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sram_arbiter
`default_nettype wire
